bn_batch_stats: RTL and testbench



---
 rtl/bn_batch_stats.sv | 90 +++++++++
 tb/tb_bn_batch_stats.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bn_batch_stats.sv
// Batch statistics stage: accumulates sum and sum of squares over 2^LOG_B samples,
// then produces the floor mean and saturated population variance on a valid/ready port.
module bn_batch_stats #(
  parameter int N     = 16,
  parameter int LOG_B = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     mean,
  output logic [2*N-1:0]   var_o,
  output logic [LOG_B:0]   count
);

  typedef enum logic [1:0] {ACC, CALC1, CALC2, OUT} state_t;

  localparam logic [LOG_B:0] LastCount = (LOG_B+1)'((1 << LOG_B) - 1);

  state_t                 state_q;
  logic [N+LOG_B-1:0]     sum_q;
  logic [2*N+LOG_B-1:0]   sumSq_q;
  logic [LOG_B:0]         count_q;
  logic [N-1:0]           mean_q;
  logic [2*N-1:0]         ex2_q;
  logic [2*N-1:0]         var_q;
  logic [2*N-1:0]         xSq_d;
  logic [2*N-1:0]         meanSq_d;

  assign xSq_d    = {{N{1'b0}}, in_data} * {{N{1'b0}}, in_data};
  assign meanSq_d = {{N{1'b0}}, mean_q} * {{N{1'b0}}, mean_q};

  // clr only matters while accumulating and wins over a sample offered the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      sum_q   <= '0;
      sumSq_q <= '0;
      count_q <= '0;
      mean_q  <= '0;
      ex2_q   <= '0;
      var_q   <= '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (clr) begin
            sum_q   <= '0;
            sumSq_q <= '0;
            count_q <= '0;
          end else if (in_valid) begin
            sum_q   <= sum_q + {{LOG_B{1'b0}}, in_data};
            sumSq_q <= sumSq_q + {{LOG_B{1'b0}}, xSq_d};
            count_q <= count_q + (LOG_B+1)'(1);
            if (count_q == LastCount) state_q <= CALC1;
          end
        end
        CALC1: begin
          mean_q  <= sum_q[N+LOG_B-1:LOG_B];
          ex2_q   <= sumSq_q[2*N+LOG_B-1:LOG_B];
          state_q <= CALC2;
        end
        CALC2: begin
          var_q   <= (ex2_q >= meanSq_d) ? (ex2_q - meanSq_d) : '0;
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            state_q <= ACC;
            sum_q   <= '0;
            sumSq_q <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  // Decoded from the state register so the async reset clears out_valid at once.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign mean      = mean_q;
  assign var_o     = var_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bn_batch_stats.sv
// Self-checking bench for bn_batch_stats: random and directed batches compared
// against a plain-arithmetic mean/variance model.
module tb_bn_batch_stats;

  localparam int N     = 16;
  localparam int LOG_B = 4;
  localparam int B     = 1 << LOG_B;

  logic             clk = 1'b0;
  logic             resetN;
  logic             clr;
  logic             inValid;
  logic [N-1:0]     inData;
  logic             inReady;
  logic             outValid;
  logic             outReady;
  logic [N-1:0]     meanOut;
  logic [2*N-1:0]   varOut;
  logic [LOG_B:0]   countOut;

  int vectors     = 0;
  int miscompares = 0;
  int batchQ[$];
  bit holdReady   = 1'b0;

  bn_batch_stats #(.N(N), .LOG_B(LOG_B)) dut (
    .clk      (clk),
    .reset_n  (resetN),
    .clr      (clr),
    .in_valid (inValid),
    .in_data  (inData),
    .in_ready (inReady),
    .out_valid(outValid),
    .out_ready(outReady),
    .mean     (meanOut),
    .var_o    (varOut),
    .count    (countOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: floor mean and floor E[x^2] minus mean^2, clamped at zero.
  task automatic model(output longint expMean, output longint expVar);
    longint s  = 0;
    longint s2 = 0;
    longint ex2;
    foreach (batchQ[i]) begin
      s  += longint'(batchQ[i]);
      s2 += longint'(batchQ[i]) * longint'(batchQ[i]);
    end
    expMean = s / B;
    ex2     = s2 / B;
    expVar  = (ex2 >= expMean * expMean) ? ex2 - expMean * expMean : 0;
  endtask

  task automatic applyStimulus(input int gapMax);
    for (int i = 0; i < batchQ.size(); i++) begin
      int gaps = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
      repeat (gaps) begin
        inValid = 1'b0;
        inData  = N'($urandom);
        tick();
      end
      inValid = 1'b1;
      inData  = N'(batchQ[i]);
      checkOutput("in_ready_acc", 64'(inReady), 64'd1);
      checkOutput("count_acc", 64'(countOut), 64'(i));
      tick();
    end
    inValid = 1'b0;
  endtask

  // Called in the cycle right after the edge that accepted the last sample.
  task automatic finishBatch(input int stallCycles, input bit doHandshake);
    longint expMean, expVar;
    model(expMean, expVar);
    checkOutput("calc1_in_ready", 64'(inReady), 64'd0);
    checkOutput("calc1_out_valid", 64'(outValid), 64'd0);
    checkOutput("calc1_count", 64'(countOut), 64'(B));
    tick();
    checkOutput("calc2_out_valid", 64'(outValid), 64'd0);
    tick();
    checkOutput("out_valid", 64'(outValid), 64'd1);
    checkOutput("mean", 64'(meanOut), 64'(expMean));
    checkOutput("var", 64'(varOut), 64'(expVar));
    checkOutput("out_count", 64'(countOut), 64'(B));
    for (int i = 0; i < stallCycles; i++) begin
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = N'($urandom);
      tick();
      checkOutput("stall_out_valid", 64'(outValid), 64'd1);
      checkOutput("stall_in_ready", 64'(inReady), 64'd0);
      checkOutput("stall_mean", 64'(meanOut), 64'(expMean));
      checkOutput("stall_var", 64'(varOut), 64'(expVar));
      checkOutput("stall_count", 64'(countOut), 64'(B));
    end
    inValid = 1'b0;
    if (doHandshake) begin
      outReady = 1'b1;
      tick();
      outReady = holdReady;
      checkOutput("post_hs_out_valid", 64'(outValid), 64'd0);
      checkOutput("post_hs_in_ready", 64'(inReady), 64'd1);
      checkOutput("post_hs_count", 64'(countOut), 64'd0);
    end
  endtask

  task automatic fillConst(input int value, input int n);
    for (int i = 0; i < n; i++) batchQ.push_back(value);
  endtask

  initial begin
    resetN   = 1'b0;
    clr      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
    #12;
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_mean", 64'(meanOut), 64'd0);
    checkOutput("rst_var", 64'(varOut), 64'd0);
    checkOutput("rst_count", 64'(countOut), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    tick();

    // All fives, back-to-back with out_ready held high.
    holdReady = 1'b1;
    outReady  = 1'b1;
    batchQ.delete();
    fillConst(5, B);
    applyStimulus(0);
    finishBatch(0, 1'b1);
    holdReady = 1'b0;
    outReady  = 1'b0;

    // Alternating 0/10 with random gaps.
    batchQ.delete();
    for (int i = 0; i < B; i++) batchQ.push_back((i % 2) ? 10 : 0);
    applyStimulus(3);
    finishBatch(1, 1'b1);

    // Ramp 0..15 exercises the truncating shifts.
    batchQ.delete();
    for (int i = 0; i < B; i++) batchQ.push_back(i);
    applyStimulus(0);
    finishBatch(0, 1'b1);

    // Full-scale samples, then half zero / half full-scale.
    batchQ.delete();
    fillConst(65535, B);
    applyStimulus(1);
    finishBatch(0, 1'b1);
    batchQ.delete();
    fillConst(0, B / 2);
    fillConst(65535, B / 2);
    applyStimulus(0);
    finishBatch(0, 1'b1);

    // Long backpressure with in_valid asserted, then a batch of threes.
    batchQ.delete();
    for (int i = 0; i < B; i++) batchQ.push_back(int'($urandom_range(0, 65535)));
    applyStimulus(2);
    finishBatch(10, 1'b1);
    batchQ.delete();
    fillConst(3, B);
    applyStimulus(0);
    finishBatch(0, 1'b1);

    // Random batches with random gaps and stalls.
    for (int b = 0; b < 4; b++) begin
      batchQ.delete();
      for (int i = 0; i < B; i++) batchQ.push_back(int'($urandom_range(0, 65535)));
      applyStimulus(3);
      finishBatch(int'($urandom_range(0, 4)), 1'b1);
    end

    // Abort a partial batch with clr while a sample is offered.
    batchQ.delete();
    for (int i = 0; i < 7; i++) batchQ.push_back(int'($urandom_range(0, 65535)));
    applyStimulus(1);
    clr     = 1'b1;
    inValid = 1'b1;
    inData  = 16'd1234;
    tick();
    clr     = 1'b0;
    inValid = 1'b0;
    checkOutput("clr_count", 64'(countOut), 64'd0);
    checkOutput("clr_in_ready", 64'(inReady), 64'd1);
    batchQ.delete();
    fillConst(9, B);
    applyStimulus(0);
    finishBatch(0, 1'b0);

    // Asynchronous reset while holding a result.
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(outValid), 64'd0);
    checkOutput("async_mean", 64'(meanOut), 64'd0);
    checkOutput("async_var", 64'(varOut), 64'd0);
    checkOutput("async_in_ready", 64'(inReady), 64'd1);
    checkOutput("async_count", 64'(countOut), 64'd0);
    #2;
    resetN = 1'b1;
    tick();

    batchQ.delete();
    for (int i = 0; i < B; i++) batchQ.push_back(int'($urandom_range(0, 65535)));
    applyStimulus(2);
    finishBatch(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
